render_pixel_sink: RTL and testbench

//   Receiving end of the renderer's 24-bit pixel AXI-Stream (TDATA/TVALID/TREADY/TLAST).

---
 rtl/render_pixel_sink.sv | 143 ++++++++++++++
 tb/tb_render_pixel_sink.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/render_pixel_sink.sv
// AXI-Stream pixel sink: raster-counts incoming pixels, writes them to a framebuffer
// port through a single-entry output register, and checks TLAST framing per frame.
module render_pixel_sink #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int PIXEL_WIDTH = 24,
  parameter int ADDR_WIDTH  = 19
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic                   enable,
  input  logic                   clr_err,
  input  logic                   s_stream_TVALID,
  output logic                   s_stream_TREADY,
  input  logic [PIXEL_WIDTH-1:0] s_stream_TDATA,
  input  logic                   s_stream_TLAST,
  output logic                   fb_we,
  output logic [ADDR_WIDTH-1:0]  fb_addr,
  output logic [PIXEL_WIDTH-1:0] fb_wdata,
  input  logic                   fb_ready,
  output logic                   frame_done,
  output logic [15:0]            frame_count,
  output logic                   err_early_last,
  output logic                   err_missing_last,
  output logic                   busy
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_FLUSH} state_t;

  state_t                 state_q;
  logic [XW-1:0]          x_q;
  logic [YW-1:0]          y_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   fb_we_q;
  logic [ADDR_WIDTH-1:0]  fb_addr_q;
  logic [PIXEL_WIDTH-1:0] fb_wdata_q;
  logic                   frame_done_q;
  logic [15:0]            frame_count_q;
  logic                   err_early_q, err_missing_q;

  logic tready, accept, at_last, in_recv;
  logic err_early_d, err_missing_d;

  // The output register can take a new pixel when empty or draining this cycle.
  always_comb begin
    tready = 1'b0;
    unique case (state_q)
      ST_RECV:  tready = !fb_we_q || fb_ready;
      ST_FLUSH: tready = 1'b1;
      default:  tready = 1'b0;
    endcase
  end

  assign accept  = s_stream_TVALID && tready;
  assign at_last = (x_q == X_LAST) && (y_q == Y_LAST);
  assign in_recv = (state_q == ST_RECV);

  // A new error in the same cycle as clr_err keeps the flag set.
  assign err_early_d   = (in_recv && accept && s_stream_TLAST && !at_last) ||
                         (err_early_q && !clr_err);
  assign err_missing_d = (in_recv && accept && !s_stream_TLAST && at_last) ||
                         (err_missing_q && !clr_err);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q       <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      addr_q        <= '0;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_wdata_q    <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      err_early_q   <= 1'b0;
      err_missing_q <= 1'b0;
    end else begin
      frame_done_q  <= 1'b0;
      err_early_q   <= err_early_d;
      err_missing_q <= err_missing_d;
      if (fb_we_q && fb_ready) fb_we_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q <= ST_RECV;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
          end
        end
        ST_RECV: begin
          if (accept) begin
            fb_we_q    <= 1'b1;
            fb_addr_q  <= addr_q;
            fb_wdata_q <= s_stream_TDATA;
            if (at_last || s_stream_TLAST) begin
              // Frame boundary (real or early TLAST): restart raster at pixel 0.
              x_q    <= '0;
              y_q    <= '0;
              addr_q <= '0;
              if (at_last) begin
                frame_done_q  <= 1'b1;
                frame_count_q <= frame_count_q + 16'd1;
              end
              if (at_last && !s_stream_TLAST) state_q <= ST_FLUSH;
              else                            state_q <= enable ? ST_RECV : ST_IDLE;
            end else begin
              addr_q <= addr_q + ADDR_WIDTH'(1);
              if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= y_q + YW'(1);
              end else begin
                x_q <= x_q + XW'(1);
              end
            end
          end
        end
        ST_FLUSH: begin
          // Discard beats until the stream's own TLAST resynchronises framing.
          if (accept && s_stream_TLAST) state_q <= enable ? ST_RECV : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_stream_TREADY  = tready;
  assign fb_we            = fb_we_q;
  assign fb_addr          = fb_addr_q;
  assign fb_wdata         = fb_wdata_q;
  assign frame_done       = frame_done_q;
  assign frame_count      = frame_count_q;
  assign err_early_last   = err_early_q;
  assign err_missing_last = err_missing_q;
  assign busy             = (state_q != ST_IDLE) || fb_we_q;

endmodule

// File: tb/tb_render_pixel_sink.sv
// Randomised scoreboard bench for render_pixel_sink at a 4x2 raster.
module tb_render_pixel_sink;
  localparam int H = 4, V = 2, PW = 24, AW = 3, NPIX = H * V;

  logic          ap_clk = 1'b0, ap_rst = 1'b1, enable = 1'b0, clr_err = 1'b0;
  logic          tvalid = 1'b0, tlast = 1'b0, fb_ready = 1'b1;
  logic [PW-1:0] tdata = '0;
  logic          tready, fb_we, frame_done, err_e, err_m, busy;
  logic [AW-1:0] fb_addr;
  logic [PW-1:0] fb_wdata;
  logic [15:0]   frame_count;

  render_pixel_sink #(.H_RES(H), .V_RES(V), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .enable(enable), .clr_err(clr_err),
    .s_stream_TVALID(tvalid), .s_stream_TREADY(tready), .s_stream_TDATA(tdata),
    .s_stream_TLAST(tlast), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .fb_ready(fb_ready), .frame_done(frame_done), .frame_count(frame_count),
    .err_early_last(err_e), .err_missing_last(err_m), .busy(busy));

  always #5 ap_clk = ~ap_clk;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  always @(posedge ap_clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pixel index within the frame, flush mode, expected writes.
  int  m_pix = 0, m_count = 0, m_done = 0;
  bit  m_flush = 0, m_early = 0, m_missing = 0;
  logic [AW+PW-1:0] sb[$];

  task automatic model_beat(input logic [PW-1:0] d, input logic l);
    if (m_flush) begin
      if (l) m_flush = 0;
      return;
    end
    sb.push_back({AW'(m_pix), d});
    if (m_pix == NPIX - 1) begin
      m_done++;
      m_count = (m_count + 1) % 65536;
      m_pix = 0;
      if (!l) begin m_missing = 1; m_flush = 1; end
    end else if (l) begin
      m_early = 1;
      m_pix = 0;
    end else begin
      m_pix++;
    end
  endtask

  // Monitor: pops the scoreboard on each completed framebuffer write.
  int done_seen = 0;
  bit hold_v = 0;
  logic [AW+PW-1:0] held, exp_w;
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      if (fb_we) begin
        if (hold_v) check("fb_hold", {fb_addr, fb_wdata}, held);
        if (fb_ready) begin
          if (sb.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL fb_unexpected_write: got addr %0h data %0h expected no write", fb_addr, fb_wdata);
          end else begin
            exp_w = sb.pop_front();
            check("fb_addr", fb_addr, exp_w[AW+PW-1:PW]);
            check("fb_wdata", fb_wdata, exp_w[PW-1:0]);
          end
          hold_v = 0;
        end else begin
          hold_v = 1;
          held = {fb_addr, fb_wdata};
        end
      end
      if (frame_done) done_seen++;
    end
  end

  // fb_ready: 0 = always ready, 1 = pattern 1,0,0, 2 = random.
  int rdy_mode = 0, rdy_ph = 0;
  always @(posedge ap_clk) begin
    #1;
    case (rdy_mode)
      0: fb_ready = 1'b1;
      1: begin fb_ready = (rdy_ph == 0); rdy_ph = (rdy_ph + 1) % 3; end
      default: fb_ready = 1'($urandom_range(0, 1));
    endcase
  end

  int first_cyc, last_cyc;

  task automatic send_beat(input logic [PW-1:0] d, input logic l, input int gap);
    int n = 0;
    bit ok = 1;
    tdata = d; tlast = l; tvalid = 1'b1;
    forever begin
      @(negedge ap_clk);
      if (tready) break;
      n++;
      if (n > 200) begin ok = 0; break; end
    end
    @(posedge ap_clk); #1;
    if (ok) begin
      model_beat(d, l);
      last_cyc = cyc;
    end else begin
      vectors++; miscompares++;
      $display("FAIL beat_timeout: got no TREADY in 200 cycles expected acceptance of %0h", d);
    end
    tvalid = 1'b0;
    repeat (gap) begin @(posedge ap_clk); #1; end
  endtask

  task automatic send_frame(input int base, input int n, input int last_at, input int gapmax);
    for (int i = 0; i < n; i++) begin
      send_beat(PW'(base + i + 1), (i == last_at), $urandom_range(0, gapmax));
      if (i == 0) first_cyc = last_cyc;
    end
  endtask

  task automatic drain_check(input string tag);
    int n = 0;
    while ((sb.size() != 0 || fb_we) && n < 200) begin @(posedge ap_clk); #2; n++; end
    @(posedge ap_clk); #2;
    check({tag, "_drain"}, sb.size(), 0);
    check({tag, "_frame_count"}, frame_count, m_count);
    check({tag, "_frame_done_pulses"}, done_seen, m_done);
    check({tag, "_err_early"}, err_e, m_early);
    check({tag, "_err_missing"}, err_m, m_missing);
  endtask

  task automatic clear_errors();
    @(posedge ap_clk); #1 clr_err = 1'b1;
    @(posedge ap_clk); #1 clr_err = 1'b0;
    m_early = 0; m_missing = 0;
    check("clr_err_early", err_e, 0);
    check("clr_err_missing", err_m, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tready"}, tready, 0);
    check({tag, "_fb_we"}, fb_we, 0);
    check({tag, "_fb_addr"}, fb_addr, 0);
    check({tag, "_fb_wdata"}, fb_wdata, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_frame_count"}, frame_count, 0);
    check({tag, "_errs"}, {err_e, err_m}, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0; enable = 1'b1;

    // Clean frame at full rate: one pixel per cycle.
    send_frame(0, 8, 7, 0);
    check("throughput", last_cyc - first_cyc, NPIX - 1);
    drain_check("clean");

    // Write-side stalls.
    rdy_mode = 1;
    send_frame(0, 8, 7, 0);
    drain_check("stall");
    rdy_mode = 0;

    // Early TLAST on 5th beat, then a clean frame.
    send_frame(32'h20, 5, 4, 0);
    drain_check("early");
    send_frame(32'h30, 8, 7, 0);
    drain_check("after_early");
    clear_errors();

    // Missing TLAST, three junk beats, then a clean frame.
    send_frame(32'h40, 8, -1, 0);
    send_frame(32'h50, 3, 2, 0);
    drain_check("missing");
    send_frame(32'h60, 8, 7, 1);
    drain_check("after_missing");
    clear_errors();

    // enable dropped mid-frame: frame finishes, then idle.
    send_frame(32'h70, 3, -1, 0);
    enable = 1'b0;
    for (int i = 3; i < 8; i++) send_beat(PW'(32'h70 + i + 1), (i == 7), 0);
    drain_check("enable_drop");
    repeat (3) @(posedge ap_clk);
    #2 check("idle_tready", tready, 0);
    check("idle_busy", busy, 0);
    enable = 1'b1;

    // Randomised frames with random write backpressure.
    rdy_mode = 2;
    for (int f = 0; f < 12; f++) begin
      case ($urandom_range(0, 2))
        0: send_frame(f * 16, 8, 7, 2);
        1: send_frame(f * 16, $urandom_range(1, 7), -2, 2);
        default: begin
          send_frame(f * 16, 8, -1, 1);
          send_frame(32'hF00, $urandom_range(1, 3), -3, 1);
          send_beat(PW'(32'hFFF), 1'b1, 0);
        end
      endcase
      if (m_pix != 0 && !m_flush) begin
        // Close a short frame with an early TLAST so the next starts at pixel 0.
        send_beat(PW'(32'hABC), 1'b1, 0);
      end
    end
    drain_check("random");
    clear_errors();
    rdy_mode = 0;

    // Asynchronous reset mid-frame.
    send_frame(32'h80, 4, -1, 0);
    #2 ap_rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    sb.delete(); hold_v = 0; done_seen = 0;
    m_pix = 0; m_count = 0; m_done = 0; m_flush = 0; m_early = 0; m_missing = 0;
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    check("post_reset_frame_count", frame_count, 0);
    send_frame(32'h90, 8, 7, 0);
    drain_check("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
